// File: rtl/encorder_4to2_if.sv
// Request/result bundle for the 4-to-2 priority encoder.
// The master drives the capture enable and request vector; the slave
// (the encoder) returns the registered index and status flags.
interface encorder_4to2_if;
    logic       en;     // capture enable
    logic [3:0] D;      // request vector, bit i = request on line i
    logic [1:0] Q;      // registered index of the winning request
    logic       valid;  // registered: at least one request was set
    logic       multi;  // registered: two or more requests were set

    modport master (
        output en,
        output D,
        input  Q,
        input  valid,
        input  multi
    );

    modport slave (
        input  en,
        input  D,
        output Q,
        output valid,
        output multi
    );
endinterface : encorder_4to2_if

// File: rtl/encorder_4to2.sv
// Registered 4-to-2 priority encoder.
// Combinational encode of D (priority direction chosen by MSB_FIRST),
// followed by a single enable-gated output register. The outputs come
// only from flops, so they never follow D or en between clock edges.
module encorder_4to2 #(
    parameter bit MSB_FIRST = 1'b1  // 1: highest set bit wins, 0: lowest wins
) (
    input  logic            clk,
    input  logic            rst_n,
    encorder_4to2_if.slave  bus
);

    // Combinational encode results
    logic [1:0] idx_hi;    // index of the highest set bit
    logic [1:0] idx_lo;    // index of the lowest set bit
    logic [1:0] idx_sel;   // index chosen by the priority direction
    logic [2:0] pop_cnt;   // number of set request bits (0..4)
    logic       any_set;
    logic       many_set;

    // Output register and its next-state
    logic [1:0] q_q,     q_d;
    logic       valid_q, valid_d;
    logic       multi_q, multi_d;

    // Priority encode from the top: highest set bit wins.
    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        idx_hi = 2'd0;
        if (bus.D[3]) begin
            idx_hi = 2'd3;
        end else if (bus.D[2]) begin
            idx_hi = 2'd2;
        end else if (bus.D[1]) begin
            idx_hi = 2'd1;
        end
    end

    // Priority encode from the bottom: lowest set bit wins.
    always_comb begin
        idx_lo = 2'd0;
        if (bus.D[0]) begin
            idx_lo = 2'd0;
        end else if (bus.D[1]) begin
            idx_lo = 2'd1;
        end else if (bus.D[2]) begin
            idx_lo = 2'd2;
        end else if (bus.D[3]) begin
            idx_lo = 2'd3;
        end
    end

    // Direction select, population count and status flags.
    // An empty vector falls through both encoders to index 0.
    always_comb begin
        idx_sel  = MSB_FIRST ? idx_hi : idx_lo;
        pop_cnt  = {2'b00, bus.D[0]} + {2'b00, bus.D[1]}
                 + {2'b00, bus.D[2]} + {2'b00, bus.D[3]};
        any_set  = |bus.D;
        many_set = (pop_cnt >= 3'd2);
    end

    // Next-state: load the fresh encode when enabled, otherwise hold.
    always_comb begin
        q_d     = q_q;
        valid_d = valid_q;
        multi_d = multi_q;
        if (bus.en) begin
            q_d     = idx_sel;
            valid_d = any_set;
            multi_d = many_set;
        end
    end

    // Single output register stage with asynchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: reset clears the outputs immediately, without waiting for a clock
    // edge; rst_n release must be synchronized to clk by the integrator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q     <= 2'd0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
        end
    end

    assign bus.Q     = q_q;
    assign bus.valid = valid_q;
    assign bus.multi = multi_q;

endmodule : encorder_4to2

// File: tb/tb_encorder_4to2.sv
// Directed self-checking bench for encorder_4to2.
// Two instances share clk/rst_n: one with MSB_FIRST=1, one with MSB_FIRST=0.
// Outputs are packed as {valid, multi, Q} and compared 1 ns after each edge.
module tb_encorder_4to2;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    encorder_4to2_if if_msb ();
    encorder_4to2_if if_lsb ();

    encorder_4to2 #(.MSB_FIRST(1'b1)) u_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_msb)
    );

    encorder_4to2 #(.MSB_FIRST(1'b0)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_lsb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run must never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] obs_msb();
        return {if_msb.valid, if_msb.multi, if_msb.Q};
    endfunction

    function automatic logic [3:0] obs_lsb();
        return {if_lsb.valid, if_lsb.multi, if_lsb.Q};
    endfunction

    // Reference model: {valid, multi, Q} for a request vector.
    function automatic logic [3:0] model(input logic [3:0] d, input bit msb_first);
        int         cnt;
        logic [1:0] q;
        cnt = 0;
        q   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (d[i]) begin
                cnt++;
                if (msb_first || cnt == 1) q = 2'(i);
            end
        end
        return {cnt != 0, cnt >= 2, q};
    endfunction

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got {valid,multi,Q}=%b, want %b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] d);
        if_msb.en = en;
        if_lsb.en = en;
        if_msb.D  = d;
        if_lsb.D  = d;
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] sweep_d   [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] sweep_exp [5] = '{4'b0000, 4'b1000, 4'b1001, 4'b1010, 4'b1011};
    logic [3:0] prio_d    [4] = '{4'b0011, 4'b0110, 4'b1010, 4'b1111};
    logic [3:0] prio_msb  [4] = '{4'b1101, 4'b1110, 4'b1111, 4'b1111};
    logic [3:0] prio_lsb  [4] = '{4'b1100, 4'b1101, 4'b1101, 4'b1100};
    logic [3:0] hold_d    [3] = '{4'b0001, 4'b1000, 4'b0001};

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        drive(1'b1, 4'b1000);

        // Reset held: edges ignored, outputs stay cleared.
        #1;
        check("reset_t0_msb", obs_msb(), 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("reset_hold%0d_msb", i), obs_msb(), 4'b0000);
            check($sformatf("reset_hold%0d_lsb", i), obs_lsb(), 4'b0000);
        end

        // Recovery: release mid-cycle with D=0010, nothing changes until the edge.
        drive(1'b1, 4'b0010);
        rst_n = 1'b1;
        #2;
        check("recover_pre_edge", obs_msb(), 4'b0000);
        step();
        check("recover_first_msb", obs_msb(), 4'b1001);
        check("recover_first_lsb", obs_lsb(), 4'b1001);

        // One-hot sweep (identical for both directions).
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, sweep_d[i]);
            step();
            check($sformatf("onehot_%b_msb", sweep_d[i]), obs_msb(), sweep_exp[i]);
            check($sformatf("onehot_%b_lsb", sweep_d[i]), obs_lsb(), sweep_exp[i]);
        end

        // Priority with multiple bits set.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, prio_d[i]);
            step();
            check($sformatf("prio_%b_msb", prio_d[i]), obs_msb(), prio_msb[i]);
            check($sformatf("prio_%b_lsb", prio_d[i]), obs_lsb(), prio_lsb[i]);
        end

        // Enable hold: load 0100, then en=0 with changing D for three edges.
        drive(1'b1, 4'b0100);
        step();
        check("hold_load_msb", obs_msb(), 4'b1010);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, hold_d[i]);
            step();
            check($sformatf("hold%0d_msb", i), obs_msb(), 4'b1010);
            check($sformatf("hold%0d_lsb", i), obs_lsb(), 4'b1010);
        end
        drive(1'b1, 4'b1000);
        step();
        check("hold_release_msb", obs_msb(), 4'b1011);
        check("hold_release_lsb", obs_lsb(), 4'b1011);

        // Mid-cycle reset assertion clears outputs with no clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_msb", obs_msb(), 4'b0000);
        check("async_reset_lsb", obs_lsb(), 4'b0000);
        step();
        check("async_reset_edge", obs_msb(), 4'b0000);
        #2;
        rst_n = 1'b1;

        // Exhaustive sweep against the reference model.
        for (int d = 0; d < 16; d++) begin
            drive(1'b1, 4'(d));
            step();
            check($sformatf("exh_%b_msb", 4'(d)), obs_msb(), model(4'(d), 1'b1));
            check($sformatf("exh_%b_lsb", 4'(d)), obs_lsb(), model(4'(d), 1'b0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_encorder_4to2
